// File: rtl/regfile_write_scheduler_if.sv
// Writeback / init request bus and register-file write port for the
// regfile write scheduler. The master side is the requester (SEQ writeback
// and the init loader); the slave side is the scheduler itself.
interface regfile_write_scheduler_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  icode;
  logic        cnd;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] ValE;
  logic [63:0] ValM;
  logic        init_valid;
  logic        init_ready;
  logic [3:0]  init_addr;
  logic [63:0] init_data;
  logic        we;
  logic [3:0]  waddr;
  logic [63:0] wdata;
  logic        busy;
  logic        err_illegal;

  modport master (
    output wb_valid, icode, cnd, rA, rB, ValE, ValM,
    output init_valid, init_addr, init_data,
    input  wb_ready, init_ready, we, waddr, wdata, busy, err_illegal
  );

  modport slave (
    input  wb_valid, icode, cnd, rA, rB, ValE, ValM,
    input  init_valid, init_addr, init_data,
    output wb_ready, init_ready, we, waddr, wdata, busy, err_illegal
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Serialises all writes into the single-write-port register file: decodes
// one writeback request per instruction, splits popq into two writes over
// two cycles, and arbitrates the port against an init requester with a
// starvation guard that force-grants init after STARVE_LIMIT blocked cycles.
module regfile_write_scheduler #(
  parameter logic [3:0] STARVE_LIMIT = 4'd4,
  parameter logic [3:0] RNONE        = 4'hF
) (
  input  logic                        clk,
  input  logic                        rst,
  regfile_write_scheduler_if.slave    bus
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WRITE2 = 1'b1} state_t;

  state_t      state_q;
  logic        we_q;
  logic [3:0]  waddr_q;
  logic [63:0] wdata_q;
  logic        err_q;
  logic [3:0]  starve_q;
  logic [3:0]  pop_addr_q;
  logic [63:0] pop_data_q;

  logic        init_force_s;
  logic        wb_ready_s;
  logic        init_ready_s;
  logic        wb_fire_s;
  logic        init_fire_s;
  logic        dec_we_s;
  logic [3:0]  dec_addr_s;
  logic [63:0] dec_data_s;
  logic        dec_pop_s;
  logic        dec_illegal_s;

  // Handshake: writeback wins unless init has been starved long enough.
  always_comb begin
    init_force_s = bus.init_valid && (starve_q == STARVE_LIMIT);
    wb_ready_s   = (state_q == ST_IDLE) && !init_force_s;
    init_ready_s = (state_q == ST_IDLE) && bus.init_valid &&
                   (!bus.wb_valid || init_force_s);
    wb_fire_s    = bus.wb_valid && wb_ready_s;
    init_fire_s  = bus.init_valid && init_ready_s && !wb_fire_s;
  end

  // Decode the first destination write of a writeback request.
  always_comb begin
    dec_we_s      = 1'b0;
    dec_addr_s    = bus.rB;
    dec_data_s    = bus.ValE;
    dec_pop_s     = 1'b0;
    dec_illegal_s = 1'b0;
    case (bus.icode)
      4'h2: begin
        dec_we_s = bus.cnd;
      end
      4'h3, 4'h6: begin
        dec_we_s = 1'b1;
      end
      4'h5: begin
        dec_we_s   = 1'b1;
        dec_addr_s = bus.rA;
        dec_data_s = bus.ValM;
      end
      4'h8, 4'h9, 4'hA: begin
        dec_we_s   = 1'b1;
        dec_addr_s = 4'h4;
      end
      4'hB: begin
        dec_we_s   = 1'b1;
        dec_addr_s = 4'h4;
        dec_pop_s  = 1'b1;
      end
      4'hC, 4'hD, 4'hE, 4'hF: begin
        dec_illegal_s = 1'b1;
      end
      default: begin
        dec_we_s = 1'b0;
      end
    endcase
    // A destination of RNONE never reaches the register file.
    if (dec_addr_s == RNONE) begin
      dec_we_s = 1'b0;
    end else begin
      dec_we_s = dec_we_s;
    end
  end

  // Scheduler FSM with registered write port, error pulse and starve counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      waddr_q    <= 4'd0;
      wdata_q    <= 64'd0;
      err_q      <= 1'b0;
      starve_q   <= 4'd0;
      pop_addr_q <= 4'd0;
      pop_data_q <= 64'd0;
    end else begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wb_fire_s) begin
            we_q    <= dec_we_s;
            waddr_q <= dec_addr_s;
            wdata_q <= dec_data_s;
            err_q   <= dec_illegal_s;
            if (dec_pop_s) begin
              state_q    <= ST_WRITE2;
              pop_addr_q <= bus.rA;
              pop_data_q <= bus.ValM;
            end
          end else if (init_fire_s) begin
            we_q    <= (bus.init_addr != RNONE);
            waddr_q <= bus.init_addr;
            wdata_q <= bus.init_data;
          end
          // Count blocked init cycles; any grant or withdrawal clears it.
          if (bus.init_valid && !init_ready_s) begin
            if (starve_q != STARVE_LIMIT) begin
              starve_q <= starve_q + 4'd1;
            end
          end else begin
            starve_q <= 4'd0;
          end
        end
        ST_WRITE2: begin
          // Second pop write: ValM lands last so popq %rsp ends with ValM.
          we_q    <= (pop_addr_q != RNONE);
          waddr_q <= pop_addr_q;
          wdata_q <= pop_data_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wb_ready    = wb_ready_s;
  assign bus.init_ready  = init_ready_s;
  assign bus.we          = we_q;
  assign bus.waddr       = waddr_q;
  assign bus.wdata       = wdata_q;
  assign bus.busy        = (state_q == ST_WRITE2);
  assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: hand-computed expectations for
// reset, irmov, cmov, popq, starvation guard, illegal icode, RNONE and
// reset during the second pop write.
module tb_regfile_write_scheduler;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_write_scheduler_if bus ();

  regfile_write_scheduler #(
    .STARVE_LIMIT(4'd4),
    .RNONE       (4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report it when observed differs from expected.
  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_wb(input logic [3:0] ic, input logic c,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] ve, input logic [63:0] vm);
    bus.wb_valid = 1'b1;
    bus.icode    = ic;
    bus.cnd      = c;
    bus.rA       = ra;
    bus.rB       = rb;
    bus.ValE     = ve;
    bus.ValM     = vm;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.wb_valid   = 1'b0;
    bus.icode      = 4'h0;
    bus.cnd        = 1'b0;
    bus.rA         = 4'h0;
    bus.rB         = 4'h0;
    bus.ValE       = 64'd0;
    bus.ValM       = 64'd0;
    bus.init_valid = 1'b0;
    bus.init_addr  = 4'h0;
    bus.init_data  = 64'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_val("rst_we",    {63'd0, bus.we},          64'd0);
    check_val("rst_waddr", {60'd0, bus.waddr},       64'd0);
    check_val("rst_wdata", bus.wdata,                64'd0);
    check_val("rst_busy",  {63'd0, bus.busy},        64'd0);
    check_val("rst_err",   {63'd0, bus.err_illegal}, 64'd0);
    check_val("rst_wbrdy", {63'd0, bus.wb_ready},    64'd1);
    check_val("rst_inrdy", {63'd0, bus.init_ready},  64'd0);

    // irmov rB=2 <- 0x1234
    send_wb(4'h3, 1'b0, 4'hF, 4'h2, 64'h1234, 64'd0);
    tick();
    bus.wb_valid = 1'b0;
    check_val("irmov_we",    {63'd0, bus.we},    64'd1);
    check_val("irmov_waddr", {60'd0, bus.waddr}, 64'd2);
    check_val("irmov_wdata", bus.wdata,          64'h1234);
    tick();
    check_val("irmov_we_off", {63'd0, bus.we}, 64'd0);

    // cmov not taken, then taken
    send_wb(4'h2, 1'b0, 4'hF, 4'h5, 64'd7, 64'd0);
    tick();
    check_val("cmov0_we", {63'd0, bus.we}, 64'd0);
    send_wb(4'h2, 1'b1, 4'hF, 4'h5, 64'd7, 64'd0);
    tick();
    bus.wb_valid = 1'b0;
    check_val("cmov1_we",    {63'd0, bus.we},    64'd1);
    check_val("cmov1_waddr", {60'd0, bus.waddr}, 64'd5);
    check_val("cmov1_wdata", bus.wdata,          64'd7);

    // popq %rsp: two writes to reg 4, ValM last
    send_wb(4'hB, 1'b0, 4'h4, 4'hF, 64'h100, 64'hAA);
    tick();
    bus.wb_valid = 1'b0;
    check_val("pop1_we",    {63'd0, bus.we},       64'd1);
    check_val("pop1_waddr", {60'd0, bus.waddr},    64'd4);
    check_val("pop1_wdata", bus.wdata,             64'h100);
    check_val("pop1_busy",  {63'd0, bus.busy},     64'd1);
    check_val("pop1_wbrdy", {63'd0, bus.wb_ready}, 64'd0);
    tick();
    check_val("pop2_we",    {63'd0, bus.we},       64'd1);
    check_val("pop2_waddr", {60'd0, bus.waddr},    64'd4);
    check_val("pop2_wdata", bus.wdata,             64'hAA);
    check_val("pop2_busy",  {63'd0, bus.busy},     64'd0);
    check_val("pop2_wbrdy", {63'd0, bus.wb_ready}, 64'd1);

    // Starvation: init blocked 4 cycles, force-granted on the 5th
    send_wb(4'h1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
    bus.init_valid = 1'b1;
    bus.init_addr  = 4'h3;
    bus.init_data  = 64'd9;
    for (int i = 0; i < 4; i++) begin
      check_val("starve_inrdy", {63'd0, bus.init_ready}, 64'd0);
      check_val("starve_wbrdy", {63'd0, bus.wb_ready},   64'd1);
      tick();
    end
    check_val("force_inrdy", {63'd0, bus.init_ready}, 64'd1);
    check_val("force_wbrdy", {63'd0, bus.wb_ready},   64'd0);
    tick();
    bus.wb_valid   = 1'b0;
    bus.init_valid = 1'b0;
    check_val("init_we",    {63'd0, bus.we},    64'd1);
    check_val("init_waddr", {60'd0, bus.waddr}, 64'd3);
    check_val("init_wdata", bus.wdata,          64'd9);
    check_val("init_wbrdy", {63'd0, bus.wb_ready}, 64'd1);

    // Illegal icode D
    send_wb(4'hD, 1'b0, 4'h1, 4'h2, 64'd5, 64'd6);
    tick();
    bus.wb_valid = 1'b0;
    check_val("ill_err", {63'd0, bus.err_illegal}, 64'd1);
    check_val("ill_we",  {63'd0, bus.we},          64'd0);
    tick();
    check_val("ill_err_off", {63'd0, bus.err_illegal}, 64'd0);

    // irmov to RNONE is suppressed but still accepted
    send_wb(4'h3, 1'b0, 4'hF, 4'hF, 64'h55, 64'd0);
    check_val("rnone_wbrdy_pre", {63'd0, bus.wb_ready}, 64'd1);
    tick();
    bus.wb_valid = 1'b0;
    check_val("rnone_we",    {63'd0, bus.we},       64'd0);
    check_val("rnone_wbrdy", {63'd0, bus.wb_ready}, 64'd1);

    // Reset during WRITE2 abandons the second write
    send_wb(4'hB, 1'b0, 4'h4, 4'hF, 64'h200, 64'hBB);
    tick();
    bus.wb_valid = 1'b0;
    check_val("rpop_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rpop_busy_after", {63'd0, bus.busy}, 64'd0);
    check_val("rpop_we_after",   {63'd0, bus.we},   64'd0);
    tick();
    check_val("rpop_we_next",    {63'd0, bus.we},   64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
